float_to_fixed: RTL and testbench
=================================

Name: float_to_fixed

Overview:
- Converts an IEEE-754 single-precision value back to an unsigned fixed-point word with FRAC_WIDTH fractional bits.
- It is the return path after floating-point arithmetic in the boost/cal datapath, for example ratio results going back into integer score logic.
- Pure RTL with no vendor IP. It uses an iterative one-bit-per-cycle shifter, a valid/ready handshake on both sides, and round-half-to-even.

Parameters:
- OUT_WIDTH, 32: output word width. Legal range 25..64.
- FRAC_WIDTH, 16: number of fractional bits in the output. Must be less than OUT_WIDTH.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- float_data  in  32  IEEE-754 single-precision input.
- data_valid_in  in  1  input valid.
- data_ready_out  out  1  block can accept input; high only in IDLE.
- result_data  out  OUT_WIDTH  fixed-point result.
- result_valid  out  1  result and flags are valid.
- result_ready  in  1  downstream accepts the result.
- overflow  out  1  result saturated to all-ones.
- nan_flag  out  1  input was NaN.
- neg_flag  out  1  input was negative and nonzero.

Behaviour:
- Reset: state=IDLE, result_data=0, result_valid=0, all flags=0, data_ready_out=1.
- FSM states: IDLE, DECODE, SHIFT, ROUND, DONE.
- IDLE: accept on the edge where data_valid_in && data_ready_out. Latch float_data and go to DECODE.
- DECODE computes: s = sign bit, e = exponent field, m = {1, mantissa} (24 bits), sh = e - 150 + FRAC_WIDTH (signed).
- DECODE bypass cases go straight to DONE:
  - e==0 (zero or denormal): result 0, no flags. This includes -0.
  - e==255 with mantissa != 0 (NaN): result 0, nan_flag=1.
  - s==1, otherwise: result 0, neg_flag=1. Sign is checked before infinity, so -Inf also gives neg_flag.
  - e==255 (+Inf), or 23+sh >= OUT_WIDTH: result all-ones, overflow=1.
  - -sh >= 26: result 0, no flags (value below half an LSB).
- DECODE otherwise: load acc=m and count k=|sh|. If k==0 go to ROUND; else go to SHIFT.
- SHIFT, one bit per cycle, decrementing count:
  - sh>0: acc shifts left.
  - sh<0: acc shifts right. guard takes the bit shifted out. sticky |= the previous guard.
  - Go to ROUND when the count reaches 0.
- ROUND: if sh<0 and guard && (sticky || acc[0]), then acc+1. Cannot overflow because OUT_WIDTH>=25. Go to DONE.
- DONE: result_valid=1; result_data and flags are driven from registers and held stable.
  - Leave to IDLE on the edge where result_ready=1.
  - Flags clear when the next result is loaded.
- Latency, with the accept edge as T:
  - Bypass path: result_valid first high after edge T+2.
  - Shift path: result_valid first high after edge T+3+k.
- data_valid_in outside IDLE is ignored; no input is buffered.
- result_ready=1 with result_valid=0 has no effect.
- rst_n low at any point, including mid-SHIFT, aborts the conversion immediately and restores reset values. The in-flight operand is discarded.

Optional Feature:
- Macro: SIGNED_OUT_EN.
- Defined:
  - result_data is two's complement.
  - Overflow test becomes 23+sh >= OUT_WIDTH-1.
  - Negative inputs are converted, with rounding applied to the magnitude followed by negation in ROUND.
  - Negative overflow and -Inf saturate to the most negative value, with overflow=1.
  - neg_flag is tied to 0.
- Undefined: unsigned behaviour exactly as described above.

Test Plan:
- Default parameters. Input 0x3F800000 (1.0): result 0x00010000, k=7, result_valid at T+10, no flags. Input 0x3F400000 (0.75): result 0x0000C000.
- Input 0x46FFFF00 (32767.5): result 0x7FFF8000 after a 7-cycle left shift. Input 0x47800000 (65536.0): result 0xFFFFFFFF, overflow=1, result_valid at T+2.
- Rounding:
  - 0x37000000 (2^-17): result 0x00000000 (tie, rounds to even).
  - 0x37C00000 (1.5*2^-16): result 0x00000002 (tie, rounds up to even).
  - 0x33000000 (e=102, -sh=32): result 0 via bypass.
- Special inputs:
  - 0x7FC00000: result 0, nan_flag=1.
  - 0xC0000000 (-2.0): result 0, neg_flag=1.
  - 0x7F800000: result all-ones, overflow=1.
  - 0x80000000: result 0, no flags.
- Backpressure: hold result_ready=0 for 5 cycles after result_valid. result_data stays stable, data_ready_out=0, and a data_valid_in pulse is ignored. On release, IDLE and data_ready_out=1 on the next cycle.
- Reset: assert rst_n=0 during SHIFT of 1.0. result_valid=0 and data_ready_out=1 immediately. A fresh 0x3F400000 afterwards gives 0x0000C000.

Source files
------------

// File: rtl/float_to_fixed.sv
// -----------------------------------------------------------------------------
// float_to_fixed
//
// Converts an IEEE-754 single-precision value into a fixed-point word with
// FRAC_WIDTH fractional bits. The mantissa is moved into place by an iterative
// shifter that handles one bit per cycle. Values that need a right shift are
// rounded half-to-even using guard and sticky bits.
//
// Optional feature, selected by the macro SIGNED_OUT_EN:
//   undefined (default) : unsigned result. Negative inputs give 0 and set
//                         neg_flag. Values that are too large saturate to
//                         all-ones.
//   defined             : two's-complement result. Negative inputs are
//                         converted. Saturation goes to the most positive or
//                         the most negative value. neg_flag is tied to 0.
//
// Ports:
//   clk            in   clock; all logic runs on the rising edge
//   rst_n          in   asynchronous active-low reset
//   float_data     in   [31:0] IEEE-754 single-precision operand
//   data_valid_in  in   operand valid
//   data_ready_out out  block can accept an operand (high only in IDLE)
//   result_data    out  [OUT_WIDTH-1:0] fixed-point result
//   result_valid   out  result_data and flags are valid
//   result_ready   in   downstream accepts the result
//   overflow       out  result was saturated
//   nan_flag       out  operand was NaN
//   neg_flag       out  operand was negative and nonzero (unsigned build only)
// -----------------------------------------------------------------------------
module float_to_fixed #(
  parameter int OUT_WIDTH  = 32,
  parameter int FRAC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          float_data,
  input  logic                 data_valid_in,
  output logic                 data_ready_out,
  output logic [OUT_WIDTH-1:0] result_data,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 overflow,
  output logic                 nan_flag,
  output logic                 neg_flag
);

  typedef enum logic [2:0] {IDLE, DECODE, SHIFT, ROUND, DONE} state_t;

`ifdef SIGNED_OUT_EN
  localparam int OVF_LIMIT = OUT_WIDTH - 1;
  localparam logic [OUT_WIDTH-1:0] MOST_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MOST_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};
`else
  localparam int OVF_LIMIT = OUT_WIDTH;
`endif

  state_t state, next_state;

  logic [31:0]          operand;
  logic [OUT_WIDTH-1:0] acc;
  logic [6:0]           count;
  logic                 right;
  logic                 guard;
  logic                 sticky;
  logic                 pend_ovf;
  logic                 pend_nan;
  logic                 pend_neg;
`ifdef SIGNED_OUT_EN
  logic                 sign;
`endif

  // Operand fields and the decode decision. The shift amount sh places the
  // mantissa LSB (weight 2^(e-150)) onto the output LSB (weight 2^-FRAC_WIDTH).
  logic                 dec_s;
  logic [7:0]           dec_e;
  logic [22:0]          dec_man;
  logic [23:0]          dec_m;
  int                   dec_sh;
  int                   dec_abs;
  logic                 dec_bypass;
  logic [OUT_WIDTH-1:0] dec_val;
  logic                 dec_ovf;
  logic                 dec_nan;
  logic                 dec_neg;

  logic                 round_up;
  logic [OUT_WIDTH-1:0] round_mag;

  assign data_ready_out = (state == IDLE);

  assign dec_s   = operand[31];
  assign dec_e   = operand[30:23];
  assign dec_man = operand[22:0];
  assign dec_m   = {1'b1, dec_man};
  assign dec_sh  = int'(dec_e) - 150 + FRAC_WIDTH;
  assign dec_abs = (dec_sh < 0) ? -dec_sh : dec_sh;

  // The order of the checks matters. NaN is tested before the sign, so a
  // negative NaN still reports nan_flag. In the unsigned build the sign is
  // tested before infinity, so -Inf reports neg_flag rather than overflow.
  // Once the value is at or below -26 bits of shift it is under half an LSB
  // and rounds to zero.
  always_comb begin
    dec_bypass = 1'b0;
    dec_val    = '0;
    dec_ovf    = 1'b0;
    dec_nan    = 1'b0;
    dec_neg    = 1'b0;
    if (dec_e == 8'h00) begin
      dec_bypass = 1'b1;
    end else if (dec_e == 8'hFF && dec_man != '0) begin
      dec_bypass = 1'b1;
      dec_nan    = 1'b1;
`ifdef SIGNED_OUT_EN
    end else if (dec_e == 8'hFF || 23 + dec_sh >= OVF_LIMIT) begin
      dec_bypass = 1'b1;
      dec_ovf    = 1'b1;
      dec_val    = dec_s ? MOST_NEG : MOST_POS;
`else
    end else if (dec_s) begin
      dec_bypass = 1'b1;
      dec_neg    = 1'b1;
    end else if (dec_e == 8'hFF || 23 + dec_sh >= OVF_LIMIT) begin
      dec_bypass = 1'b1;
      dec_ovf    = 1'b1;
      dec_val    = '1;
`endif
    end else if (dec_sh <= -26) begin
      dec_bypass = 1'b1;
    end
  end

  // Round half to even. This applies only when bits were shifted out to the
  // right. Because OUT_WIDTH is at least 25, the increment cannot carry out.
  assign round_up  = right && guard && (sticky || acc[0]);
  assign round_mag = acc + OUT_WIDTH'(round_up);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic. The last shift happens on the edge where count is 1,
  // and ROUND follows that edge.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (data_valid_in) next_state = DECODE;
      DECODE: begin
        if (dec_bypass)        next_state = DONE;
        else if (dec_abs == 0) next_state = ROUND;
        else                   next_state = SHIFT;
      end
      SHIFT:   if (count == 7'd1) next_state = ROUND;
      ROUND:   next_state = DONE;
      DONE:    if (result_valid && result_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath. DONE publishes acc and the pending flags into the output
  // registers on its first cycle. After that the outputs hold stable until
  // the consumer takes them. The outputs keep their last values until the
  // next result is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand      <= '0;
      acc          <= '0;
      count        <= '0;
      right        <= 1'b0;
      guard        <= 1'b0;
      sticky       <= 1'b0;
      pend_ovf     <= 1'b0;
      pend_nan     <= 1'b0;
      pend_neg     <= 1'b0;
`ifdef SIGNED_OUT_EN
      sign         <= 1'b0;
`endif
      result_data  <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
      nan_flag     <= 1'b0;
      neg_flag     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (data_valid_in) operand <= float_data;
        end
        DECODE: begin
          acc      <= dec_bypass ? dec_val : OUT_WIDTH'(dec_m);
          count    <= 7'(dec_abs);
          right    <= (dec_sh < 0);
          guard    <= 1'b0;
          sticky   <= 1'b0;
          pend_ovf <= dec_ovf;
          pend_nan <= dec_nan;
          pend_neg <= dec_neg;
`ifdef SIGNED_OUT_EN
          sign     <= dec_s && !dec_bypass;
`endif
        end
        SHIFT: begin
          count <= count - 7'd1;
          if (right) begin
            acc    <= acc >> 1;
            guard  <= acc[0];
            sticky <= sticky | guard;
          end else begin
            acc <= acc << 1;
          end
        end
        ROUND: begin
`ifdef SIGNED_OUT_EN
          acc <= sign ? (~round_mag + 1'b1) : round_mag;
`else
          acc <= round_mag;
`endif
        end
        DONE: begin
          if (!result_valid) begin
            result_data  <= acc;
            overflow     <= pend_ovf;
            nan_flag     <= pend_nan;
            neg_flag     <= pend_neg;
            result_valid <= 1'b1;
          end else if (result_ready) begin
            result_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_fixed.sv
// -----------------------------------------------------------------------------
// tb_float_to_fixed
//
// Directed self-checking bench for float_to_fixed in its default unsigned
// build (OUT_WIDTH=32, FRAC_WIDTH=16). The expected values are worked out by
// hand from the IEEE-754 encodings.
// -----------------------------------------------------------------------------
module tb_float_to_fixed;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] float_data = '0;
  logic        data_valid_in = 1'b0;
  logic        data_ready_out;
  logic [31:0] result_data;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic        overflow;
  logic        nan_flag;
  logic        neg_flag;

  int checks   = 0;
  int failures = 0;

  float_to_fixed #(.OUT_WIDTH(32), .FRAC_WIDTH(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .float_data    (float_data),
    .data_valid_in (data_valid_in),
    .data_ready_out(data_ready_out),
    .result_data   (result_data),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .overflow      (overflow),
    .nan_flag      (nan_flag),
    .neg_flag      (neg_flag)
  );

  always #5 clk = ~clk;

  // Precondition: the DUT is in IDLE. The task presents one operand and counts
  // the edges after the accept edge until result_valid is seen. It then
  // returns the outputs and consumes the result.
  task automatic convert(input logic [31:0] f, output logic [31:0] res,
                         output logic [2:0] flags, output int lat);
    int n;
    float_data    = f;
    data_valid_in = 1'b1;
    @(posedge clk); #1;
    data_valid_in = 1'b0;
    n   = 0;
    lat = -1;
    while (n < 200 && lat < 0) begin
      @(posedge clk); #1;
      n++;
      if (result_valid) lat = n;
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL timeout operand=%h no result_valid within 200 cycles", f);
    end
    res   = result_data;
    flags = {overflow, nan_flag, neg_flag};
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (result_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_valid got=%b exp=0", result_valid);
    end
    checks++;
    if (data_ready_out !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_ready got=%b exp=1", data_ready_out);
    end
    checks++;
    if (result_data !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_data got=%h exp=00000000", result_data);
    end
    checks++;
    if ({overflow, nan_flag, neg_flag} !== 3'b000) begin
      failures++; $display("[TB] FAIL reset_flags got=%b exp=000", {overflow, nan_flag, neg_flag});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Values that go through the shifter, plus the overflow and zero bypasses.
  // flags are ordered {overflow, nan, neg}.
  task automatic test_conversion();
    logic [31:0] fin [7];
    logic [31:0] exp_res [7];
    logic [2:0]  exp_flags [7];
    int          exp_lat [7];
    logic [31:0] r;
    logic [2:0]  fl;
    int          lat;
    fin[0] = 32'h3F800000; exp_res[0] = 32'h00010000; exp_flags[0] = 3'b000; exp_lat[0] = 10;
    fin[1] = 32'h3F400000; exp_res[1] = 32'h0000C000; exp_flags[1] = 3'b000; exp_lat[1] = 11;
    fin[2] = 32'h46FFFF00; exp_res[2] = 32'h7FFF8000; exp_flags[2] = 3'b000; exp_lat[2] = 10;
    fin[3] = 32'h47800000; exp_res[3] = 32'hFFFFFFFF; exp_flags[3] = 3'b100; exp_lat[3] = 2;
    fin[4] = 32'h37000000; exp_res[4] = 32'h00000000; exp_flags[4] = 3'b000; exp_lat[4] = 27;
    fin[5] = 32'h37C00000; exp_res[5] = 32'h00000002; exp_flags[5] = 3'b000; exp_lat[5] = 26;
    fin[6] = 32'h33000000; exp_res[6] = 32'h00000000; exp_flags[6] = 3'b000; exp_lat[6] = 2;
    for (int i = 0; i < 7; i++) begin
      convert(fin[i], r, fl, lat);
      checks++;
      if (r !== exp_res[i]) begin
        failures++; $display("[TB] FAIL conv_result in=%h got=%h exp=%h", fin[i], r, exp_res[i]);
      end
      checks++;
      if (fl !== exp_flags[i]) begin
        failures++; $display("[TB] FAIL conv_flags in=%h got=%b exp=%b", fin[i], fl, exp_flags[i]);
      end
      checks++;
      if (lat !== exp_lat[i]) begin
        failures++; $display("[TB] FAIL conv_latency in=%h got=%0d exp=%0d", fin[i], lat, exp_lat[i]);
      end
    end
  endtask

  // NaN, negative, +Inf, -0 and -Inf. All of these take the two-cycle bypass.
  task automatic test_special();
    logic [31:0] fin [5];
    logic [31:0] exp_res [5];
    logic [2:0]  exp_flags [5];
    logic [31:0] r;
    logic [2:0]  fl;
    int          lat;
    fin[0] = 32'h7FC00000; exp_res[0] = 32'h00000000; exp_flags[0] = 3'b010;
    fin[1] = 32'hC0000000; exp_res[1] = 32'h00000000; exp_flags[1] = 3'b001;
    fin[2] = 32'h7F800000; exp_res[2] = 32'hFFFFFFFF; exp_flags[2] = 3'b100;
    fin[3] = 32'h80000000; exp_res[3] = 32'h00000000; exp_flags[3] = 3'b000;
    fin[4] = 32'hFF800000; exp_res[4] = 32'h00000000; exp_flags[4] = 3'b001;
    for (int i = 0; i < 5; i++) begin
      convert(fin[i], r, fl, lat);
      checks++;
      if (r !== exp_res[i]) begin
        failures++; $display("[TB] FAIL special_result in=%h got=%h exp=%h", fin[i], r, exp_res[i]);
      end
      checks++;
      if (fl !== exp_flags[i]) begin
        failures++; $display("[TB] FAIL special_flags in=%h got=%b exp=%b", fin[i], fl, exp_flags[i]);
      end
      checks++;
      if (lat !== 2) begin
        failures++; $display("[TB] FAIL special_latency in=%h got=%0d exp=2", fin[i], lat);
      end
    end
  endtask

  // Hold the result for five cycles. While it is held, an input pulse must be
  // ignored and nothing may change.
  task automatic test_backpressure();
    int n;
    float_data    = 32'h3F800000;
    data_valid_in = 1'b1;
    @(posedge clk); #1;
    data_valid_in = 1'b0;
    n = 0;
    while (n < 200 && !result_valid) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (result_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL bp_valid got=%b exp=1", result_valid);
    end
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        float_data    = 32'h40000000;
        data_valid_in = 1'b1;
      end
      @(posedge clk); #1;
      data_valid_in = 1'b0;
      checks++;
      if (result_data !== 32'h00010000 || result_valid !== 1'b1 || data_ready_out !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bp_hold cycle=%0d data=%h valid=%b ready=%b exp data=00010000 valid=1 ready=0",
                 c, result_data, result_valid, data_ready_out);
      end
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || data_ready_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_release valid=%b ready=%b exp valid=0 ready=1", result_valid, data_ready_out);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (result_valid !== 1'b0 || data_ready_out !== 1'b1 || result_data !== 32'h00010000) begin
      failures++;
      $display("[TB] FAIL bp_ignored_pulse valid=%b ready=%b data=%h exp valid=0 ready=1 data=00010000",
               result_valid, data_ready_out, result_data);
    end
  endtask

  // Abort 1.0 in the middle of SHIFT. Afterwards, convert a fresh operand.
  task automatic test_reset_mid_shift();
    logic [31:0] r;
    logic [2:0]  fl;
    int          lat;
    float_data    = 32'h3F800000;
    data_valid_in = 1'b1;
    @(posedge clk); #1;
    data_valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (data_ready_out !== 1'b0) begin
      failures++; $display("[TB] FAIL midshift_busy got=%b exp=0", data_ready_out);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (result_valid !== 1'b0 || data_ready_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midshift_abort valid=%b ready=%b exp valid=0 ready=1", result_valid, data_ready_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    convert(32'h3F400000, r, fl, lat);
    checks++;
    if (r !== 32'h0000C000) begin
      failures++; $display("[TB] FAIL midshift_fresh got=%h exp=0000c000", r);
    end
    checks++;
    if (fl !== 3'b000) begin
      failures++; $display("[TB] FAIL midshift_fresh_flags got=%b exp=000", fl);
    end
  endtask

  initial begin
    test_reset();
    test_conversion();
    test_special();
    test_backpressure();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
